// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST signature checker: FSM state encoding,
// MISR geometry defaults and the cycle-counter saturation value.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'hFFFF;
  localparam logic [15:0] CYC_MAX   = 16'hFFFF;

endpackage

// File: rtl/bist_signature_checker_if.sv
// Controller-side and result-side signals of the BIST signature checker,
// plus the FSM state exposed for debug.
interface bist_signature_checker_if #(
  parameter int DATA_W = 4,
  parameter int SIG_W  = 16
);
  import bist_pkg::*;

  logic              running;
  logic              out_en;
  logic              bist_end;
  logic [DATA_W-1:0] cut_resp;
  logic [SIG_W-1:0]  golden_sig;
  logic              result_ack;

  logic [SIG_W-1:0]  signature;
  logic [15:0]       cyc_cnt;
  logic              busy;
  logic              result_valid;
  logic              pass;
  logic              abort;
  logic              overrun;
  state_t            dbg_state;

  // Result handshake: result_valid stays high with pass/abort stable until a
  // cycle where result_ack is high; that edge consumes the result. result_ack
  // seen while result_valid is low has no effect.
  modport master (
    output running, out_en, bist_end, cut_resp, golden_sig, result_ack,
    input  signature, cyc_cnt, busy, result_valid, pass, abort, overrun, dbg_state
  );

  modport slave (
    input  running, out_en, bist_end, cut_resp, golden_sig, result_ack,
    output signature, cyc_cnt, busy, result_valid, pass, abort, overrun, dbg_state
  );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: reloads SEED on load, otherwise shifts
// left with polynomial feedback and XORs in the zero-extended response.
module bist_misr #(
  parameter int               DATA_W = 4,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] step;

  assign step = {sig[SIG_W-2:0], 1'b0}
              ^ (sig[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= step;
    end
  end

endmodule

// File: rtl/bist_signature_checker.sv
// Compacts the CUT response during a BIST run, compares the final signature
// with the golden value and holds the verdict until acknowledged.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int               DATA_W = 4,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
  input logic                      clk,
  input logic                      reset,
  bist_signature_checker_if.slave  bus
);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig;
  logic [15:0]      cyc_q;
  logic             pass_q, pass_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;
  logic             misr_load, misr_en;
  logic             cnt_clr, cnt_inc;

  bist_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (misr_load),
    .en    (misr_en),
    .data  (bus.cut_resp),
    .sig   (sig)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pass_q    <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (cnt_clr) begin
      cyc_q <= '0;
    end else if (cnt_inc && (cyc_q != CYC_MAX)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    abort_d   = abort_q;
    overrun_d = overrun_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.running) begin
          state_d   = COMPACT;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      COMPACT: begin
        // A sample arriving with bist_end is folded in before the compare.
        misr_en = bus.out_en;
        cnt_inc = bus.out_en;
        if (bus.bist_end) begin
          state_d = COMPARE;
        end else if (!bus.running) begin
          state_d = REPORT;
          abort_d = 1'b1;
          pass_d  = 1'b0;
        end
      end
      COMPARE: begin
        pass_d  = (sig == bus.golden_sig);
        abort_d = 1'b0;
        state_d = REPORT;
      end
      REPORT: begin
        // A new run discards the pending verdict; flag it if nobody took it.
        if (bus.running) begin
          overrun_d = overrun_q | ~bus.result_ack;
          state_d   = COMPACT;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
          pass_d    = 1'b0;
          abort_d   = 1'b0;
        end else if (bus.result_ack) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          abort_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.signature    = sig;
  assign bus.cyc_cnt      = cyc_q;
  assign bus.busy         = (state_q == COMPACT) || (state_q == COMPARE);
  assign bus.result_valid = (state_q == REPORT);
  assign bus.pass         = pass_q;
  assign bus.abort        = abort_q;
  assign bus.overrun      = overrun_q;
  assign bus.dbg_state    = state_q;

endmodule
